// File: rtl/pipe_stage_reg.sv
// Pipeline-boundary register with NCH independent write channels, stall/flush
// control and saturating stall/bubble performance counters.
module pipe_stage_reg #(
  parameter int unsigned STAGE = 4,
  parameter int unsigned NCH   = 4,
  parameter int unsigned PW    = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          stall,
  input  logic                flush,
  input  logic                in_valid,
  input  logic [31:0]         in_pc,
  input  logic [NCH-1:0]      in_we,
  input  logic [NCH*PW-1:0]   in_data,
  output logic                out_valid,
  output logic [31:0]         out_pc,
  output logic [NCH-1:0]      out_we,
  output logic [NCH*PW-1:0]   out_data,
  input  logic                cnt_clr,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    bubble_cnt
);

  typedef enum logic [2:0] {
    ACT_RESET,
    ACT_FLUSH,
    ACT_BUBBLE,
    ACT_HOLD,
    ACT_ADVANCE
  } action_e;

  action_e             w_action;
  logic                w_stall_up;
  logic                w_stall_dn;
  logic                w_bubble;
  logic [NCH-1:0]      w_we_gated;
  logic [CNT_W-1:0]    w_stall_cnt_nxt;
  logic [CNT_W-1:0]    w_bubble_cnt_nxt;
  logic                w_unused_stall;

  logic                r_valid;
  logic [31:0]         r_pc;
  logic [NCH-1:0]      r_we;
  logic [NCH*PW-1:0]   r_data;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [CNT_W-1:0]    r_bubble_cnt;

  assign w_stall_up     = stall[STAGE];
  assign w_stall_dn     = stall[STAGE+1];
  assign w_unused_stall = ^stall;

  // Fixed-priority action decode; exactly one action applies per cycle.
  always_comb begin
    w_action = ACT_ADVANCE;
    if (rst)                            w_action = ACT_RESET;
    else if (flush)                     w_action = ACT_FLUSH;
    else if (w_stall_up && !w_stall_dn) w_action = ACT_BUBBLE;
    else if (w_stall_up)                w_action = ACT_HOLD;
  end

  // The registered result is a bubble if it is squashed/inserted, or if the
  // held or newly loaded entry is not a real instruction.
  always_comb begin
    w_bubble = 1'b0;
    case (w_action)
      ACT_FLUSH,
      ACT_BUBBLE:  w_bubble = 1'b1;
      ACT_HOLD:    w_bubble = !r_valid;
      ACT_ADVANCE: w_bubble = !in_valid;
      default:     w_bubble = 1'b0;
    endcase
  end

  assign w_we_gated = in_valid ? in_we : '0;

  always_comb begin
    w_stall_cnt_nxt  = r_stall_cnt;
    w_bubble_cnt_nxt = r_bubble_cnt;
    if (cnt_clr) begin
      w_stall_cnt_nxt  = '0;
      w_bubble_cnt_nxt = '0;
    end else begin
      if (w_stall_up && (r_stall_cnt != '1))
        w_stall_cnt_nxt = r_stall_cnt + 1'b1;
      if (w_bubble && (r_bubble_cnt != '1))
        w_bubble_cnt_nxt = r_bubble_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    case (w_action)
      ACT_RESET,
      ACT_FLUSH,
      ACT_BUBBLE: begin
        r_valid <= 1'b0;
        r_pc    <= '0;
        r_we    <= '0;
        r_data  <= '0;
      end
      ACT_HOLD: begin
        r_valid <= r_valid;
        r_pc    <= r_pc;
        r_we    <= r_we;
        r_data  <= r_data;
      end
      default: begin
        r_valid <= in_valid;
        r_pc    <= in_pc;
        r_we    <= w_we_gated;
        r_data  <= in_data;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      r_stall_cnt  <= w_stall_cnt_nxt;
      r_bubble_cnt <= w_bubble_cnt_nxt;
    end
  end

  assign out_valid  = r_valid;
  assign out_pc     = r_pc;
  assign out_we     = r_we;
  assign out_data   = r_data;
  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg (STAGE=4, NCH=4, PW=32, CNT_W=4).
module tb_pipe_stage_reg;

  localparam int NCH = 4;
  localparam int PW  = 32;
  localparam int CW  = 4;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, cnt_clr;
  logic [5:0]      stall;
  logic [31:0]     in_pc;
  logic [NCH-1:0]  in_we;
  logic [NCH*PW-1:0] in_data;
  logic            out_valid;
  logic [31:0]     out_pc;
  logic [NCH-1:0]  out_we;
  logic [NCH*PW-1:0] out_data;
  logic [CW-1:0]   stall_cnt, bubble_cnt;

  typedef struct {
    logic [NCH*PW+1+32+NCH+2*CW-1:0] snap;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // reference state, updated from the operating rules
  logic            m_v;
  logic [31:0]     m_pc;
  logic [NCH-1:0]  m_we;
  logic [NCH*PW-1:0] m_d;
  logic [CW-1:0]   m_sc, m_bc;

  always #5 clk = ~clk;

  pipe_stage_reg #(.STAGE(4), .NCH(NCH), .PW(PW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_pc(in_pc), .in_we(in_we), .in_data(in_data), .out_valid(out_valid),
    .out_pc(out_pc), .out_we(out_we), .out_data(out_data), .cnt_clr(cnt_clr),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  function automatic logic [NCH*PW+1+32+NCH+2*CW-1:0] dut_snap();
    return {out_valid, out_pc, out_we, out_data, stall_cnt, bubble_cnt};
  endfunction

  task automatic drive_cycle(input logic r, input logic [5:0] s, input logic f,
                             input logic v, input logic [31:0] pc,
                             input logic [NCH-1:0] we, input logic [NCH*PW-1:0] d,
                             input logic cc);
    logic bub;
    exp_t e;
    rst = r; stall = s; flush = f; in_valid = v; in_pc = pc; in_we = we;
    in_data = d; cnt_clr = cc;
    if (r) begin
      m_v = 0; m_pc = '0; m_we = '0; m_d = '0; m_sc = '0; m_bc = '0;
    end else begin
      bub = f || (s[4] && !s[5]) || (s[4] && s[5] && !m_v) || (!s[4] && !v);
      if (cc) begin
        m_sc = '0; m_bc = '0;
      end else begin
        if (s[4] && m_sc != 4'hF) m_sc = m_sc + 1'b1;
        if (bub && m_bc != 4'hF)  m_bc = m_bc + 1'b1;
      end
      if (f || (s[4] && !s[5])) begin
        m_v = 0; m_pc = '0; m_we = '0; m_d = '0;
      end else if (!s[4]) begin
        m_v = v; m_pc = pc; m_we = v ? we : '0; m_d = d;
      end
    end
    e.snap = {m_v, m_pc, m_we, m_d, m_sc, m_bc};
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NCH*PW-1:0] rnd_data();
    logic [NCH*PW-1:0] d;
    for (int i = 0; i < NCH; i++) d[i*PW +: PW] = $urandom;
    return d;
  endfunction

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b1, 6'($urandom), 1'($urandom), 1'($urandom), $urandom,
                  4'($urandom), rnd_data(), 1'($urandom));
      e = q.pop_front();
      checks++;
      if (dut_snap() !== '0) begin
        errors++;
        $display("FAIL reset_state: got %h expected 0", dut_snap());
      end
      checks++;
      if (dut_snap() !== e.snap) begin
        errors++;
        $display("FAIL reset_model: got %h expected %h", dut_snap(), e.snap);
      end
    end
  endtask

  task automatic test_advance();
    exp_t e;
    logic [NCH*PW-1:0] d;
    d = '0;
    d[0*PW +: PW] = 32'hDEAD_BEEF;
    d[2*PW +: PW] = 32'h1234_5678;
    drive_cycle(1'b0, 6'b000000, 1'b0, 1'b1, 32'h0000_0100, 4'b0101, d, 1'b0);
    e = q.pop_front();
    checks++;
    if ({out_valid, out_we, out_pc} !== {1'b1, 4'b0101, 32'h0000_0100}) begin
      errors++;
      $display("FAIL advance_ctl: got v=%b we=%b pc=%h expected v=1 we=0101 pc=00000100",
               out_valid, out_we, out_pc);
    end
    checks++;
    if (out_data[0 +: PW] !== 32'hDEAD_BEEF || out_data[2*PW +: PW] !== 32'h1234_5678) begin
      errors++;
      $display("FAIL advance_data: got ch0=%h ch2=%h expected DEADBEEF 12345678",
               out_data[0 +: PW], out_data[2*PW +: PW]);
    end
    checks++;
    if (dut_snap() !== e.snap) begin
      errors++;
      $display("FAIL advance_model: got %h expected %h", dut_snap(), e.snap);
    end
  endtask

  task automatic test_bubble_hold();
    exp_t e;
    logic [NCH*PW-1:0] d;
    logic [NCH*PW+1+32+NCH-1:0] held;
    d = rnd_data();
    drive_cycle(1'b0, 6'b000000, 1'b0, 1'b1, 32'h200, 4'b1111, d, 1'b1);
    e = q.pop_front();
    drive_cycle(1'b0, 6'b011111, 1'b0, 1'b1, 32'h204, 4'b1111, rnd_data(), 1'b0);
    e = q.pop_front();
    checks++;
    if ({out_valid, out_we, out_data, bubble_cnt} !== {1'b0, 4'b0000, 128'h0, 4'd1}) begin
      errors++;
      $display("FAIL bubble_insert: got v=%b we=%b data=%h bc=%0d expected 0 0 0 1",
               out_valid, out_we, out_data, bubble_cnt);
    end
    drive_cycle(1'b0, 6'b000000, 1'b0, 1'b1, 32'h300, 4'b1010, d, 1'b1);
    e = q.pop_front();
    held = {out_valid, out_pc, out_we, out_data};
    for (int i = 1; i <= 3; i++) begin
      drive_cycle(1'b0, 6'b111111, 1'b0, 1'b1, $urandom, 4'($urandom), rnd_data(), 1'b0);
      e = q.pop_front();
      checks++;
      if ({out_valid, out_pc, out_we, out_data} !== {1'b1, 32'h300, 4'b1010, d} ||
          stall_cnt !== 4'(i) || bubble_cnt !== 4'd0) begin
        errors++;
        $display("FAIL hold_%0d: got v=%b pc=%h we=%b sc=%0d bc=%0d expected 1 00000300 1010 %0d 0",
                 i, out_valid, out_pc, out_we, stall_cnt, bubble_cnt, i);
      end
      checks++;
      if ({out_valid, out_pc, out_we, out_data} !== held || dut_snap() !== e.snap) begin
        errors++;
        $display("FAIL hold_model_%0d: got %h expected %h", i, dut_snap(), e.snap);
      end
    end
  endtask

  task automatic test_flush();
    exp_t e;
    drive_cycle(1'b0, 6'b000000, 1'b0, 1'b1, 32'h400, 4'b0011, rnd_data(), 1'b1);
    e = q.pop_front();
    drive_cycle(1'b0, 6'b111111, 1'b1, 1'b1, 32'h404, 4'b1111, rnd_data(), 1'b0);
    e = q.pop_front();
    checks++;
    if ({out_valid, out_we, out_pc, out_data, stall_cnt, bubble_cnt} !==
        {1'b0, 4'b0, 32'h0, 128'h0, 4'd1, 4'd1}) begin
      errors++;
      $display("FAIL flush_hold: got v=%b we=%b pc=%h sc=%0d bc=%0d expected 0 0 0 1 1",
               out_valid, out_we, out_pc, stall_cnt, bubble_cnt);
    end
    checks++;
    if (dut_snap() !== e.snap) begin
      errors++;
      $display("FAIL flush_model: got %h expected %h", dut_snap(), e.snap);
    end
  endtask

  task automatic test_invalid_gating();
    exp_t e;
    logic [NCH*PW-1:0] d;
    d = rnd_data();
    drive_cycle(1'b0, 6'b000000, 1'b0, 1'b0, 32'h500, 4'b1111, d, 1'b1);
    e = q.pop_front();
    checks++;
    if (out_we !== 4'b0000 || out_data !== d || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL invalid_gating: got v=%b we=%b data=%h expected v=0 we=0000 data=%h",
               out_valid, out_we, out_data, d);
    end
    drive_cycle(1'b0, 6'b000000, 1'b0, 1'b0, 32'h504, 4'b1111, d, 1'b0);
    e = q.pop_front();
    checks++;
    if (bubble_cnt !== 4'd1 || dut_snap() !== e.snap) begin
      errors++;
      $display("FAIL invalid_bubble_cnt: got %h expected %h", dut_snap(), e.snap);
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    drive_cycle(1'b0, 6'b000000, 1'b0, 1'b1, 32'h600, 4'b0001, rnd_data(), 1'b1);
    e = q.pop_front();
    for (int i = 1; i <= 20; i++) begin
      drive_cycle(1'b0, 6'b111111, 1'b0, 1'b1, $urandom, 4'($urandom), rnd_data(), 1'b0);
      e = q.pop_front();
      checks++;
      if (stall_cnt !== ((i > 15) ? 4'd15 : 4'(i)) || dut_snap() !== e.snap) begin
        errors++;
        $display("FAIL sat_stall_cnt_%0d: got %0d expected %0d", i, stall_cnt,
                 (i > 15) ? 15 : i);
      end
    end
    drive_cycle(1'b0, 6'b111111, 1'b0, 1'b1, $urandom, 4'($urandom), rnd_data(), 1'b1);
    e = q.pop_front();
    checks++;
    if (stall_cnt !== 4'd0 || bubble_cnt !== 4'd0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL cnt_clr: got sc=%0d bc=%0d v=%b expected 0 0 1",
               stall_cnt, bubble_cnt, out_valid);
    end
    for (int i = 1; i <= 17; i++) begin
      drive_cycle(1'b0, 6'b011111, 1'b0, 1'b1, $urandom, 4'($urandom), rnd_data(), 1'b0);
      e = q.pop_front();
    end
    checks++;
    if (bubble_cnt !== 4'd15 || dut_snap() !== e.snap) begin
      errors++;
      $display("FAIL sat_bubble_cnt: got %0d expected 15", bubble_cnt);
    end
  endtask

  task automatic test_reset_mid_stall();
    exp_t e;
    drive_cycle(1'b0, 6'b000000, 1'b0, 1'b1, 32'h700, 4'b1100, rnd_data(), 1'b0);
    e = q.pop_front();
    drive_cycle(1'b0, 6'b111111, 1'b0, 1'b1, 32'h704, 4'b0000, rnd_data(), 1'b0);
    e = q.pop_front();
    drive_cycle(1'b1, 6'b111111, 1'b0, 1'b1, 32'h708, 4'b1111, rnd_data(), 1'b0);
    e = q.pop_front();
    checks++;
    if (dut_snap() !== '0) begin
      errors++;
      $display("FAIL reset_mid_stall: got %h expected 0", dut_snap());
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [5:0] s;
    for (int i = 0; i < 200; i++) begin
      s = 6'($urandom);
      drive_cycle(($urandom_range(0, 49) == 0), s, ($urandom_range(0, 9) == 0),
                  1'($urandom), $urandom, 4'($urandom), rnd_data(),
                  ($urandom_range(0, 29) == 0));
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL b2b_queue: got empty expected entry");
      end else begin
        e = q.pop_front();
        checks++;
        if (dut_snap() !== e.snap) begin
          errors++;
          $display("FAIL b2b_%0d: got %h expected %h", i, dut_snap(), e.snap);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; stall = '0; flush = 1'b0; in_valid = 1'b0; in_pc = '0;
    in_we = '0; in_data = '0; cnt_clr = 1'b0;
    m_v = 0; m_pc = '0; m_we = '0; m_d = '0; m_sc = '0; m_bc = '0;
    test_reset();
    test_advance();
    test_bubble_hold();
    test_flush();
    test_invalid_gating();
    test_saturation();
    test_reset_mid_stall();
    test_back_to_back();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
